// File: rtl/uart_echo_responder_if.sv
// Handshake bundle between uart_echo_responder (master side) and the Uart core / bench (slave side).
interface uart_echo_responder_if #(
    parameter int DEPTH = 16
) ();
    localparam int CW = $clog2(DEPTH) + 1;

    logic          enable;
    logic          uart_rx_valid;
    logic [7:0]    uart_rx_data;
    logic          uart_rx_break;
    logic          uart_rx_en;
    logic          uart_tx_busy;
    logic          uart_tx_en;
    logic [7:0]    uart_tx_data;
    logic [CW-1:0] fifo_count;
    logic          overflow;
    logic          clear_ovf;

    modport master (
        input  enable, uart_rx_valid, uart_rx_data, uart_rx_break, uart_tx_busy, clear_ovf,
        output uart_rx_en, uart_tx_en, uart_tx_data, fifo_count, overflow
    );

    modport slave (
        output enable, uart_rx_valid, uart_rx_data, uart_rx_break, uart_tx_busy, clear_ovf,
        input  uart_rx_en, uart_tx_en, uart_tx_data, fifo_count, overflow
    );
endinterface

// File: rtl/uart_echo_responder.sv
// Loopback peer for the Uart core: queues received bytes and replays them through the TX start/busy handshake.
// Optional build macro UART_ECHO_UPCASE_EN folds ASCII lower case to upper case at the TX data latch.
module uart_echo_responder #(
    parameter int DEPTH        = 16,
    parameter int BUSY_TIMEOUT = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    uart_echo_responder_if.master bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int TW = $clog2(BUSY_TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_START     = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_DONE = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [TW-1:0] r_timer;
    logic          r_tx_en;
    logic [7:0]    r_tx_data;
    logic          r_rx_en;
    logic          r_overflow;
    logic          w_empty;
    logic          w_full;
    logic          w_pop;
    logic          w_push_req;
    logic          w_push;
    logic          w_drop;
    logic          w_timeout;

`ifdef UART_ECHO_UPCASE_EN
    function automatic logic [7:0] tx_map(input logic [7:0] b);
        if ((b >= 8'h61) && (b <= 8'h7A)) begin
            tx_map = b - 8'h20;
        end else begin
            tx_map = b;
        end
    endfunction
`else
    function automatic logic [7:0] tx_map(input logic [7:0] b);
        tx_map = b;
    endfunction
`endif

    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == CW'(DEPTH));
    assign w_timeout  = (r_timer == TW'(BUSY_TIMEOUT - 1));
    assign w_push_req = bus.uart_rx_valid & bus.enable & ~bus.uart_rx_break;
    // A pop frees the slot in the same cycle, so a full FIFO still accepts a push then.
    assign w_push     = w_push_req & (~w_full | w_pop);
    assign w_drop     = w_push_req & w_full & ~w_pop;

    // TX sequencer next-state; break holds off a new start so the flushed head is never sent.
    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty && !bus.uart_tx_busy && !bus.uart_rx_break) begin
                    w_state_next = ST_START;
                    w_pop        = 1'b1;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_START: begin
                w_state_next = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (bus.uart_tx_busy) begin
                    w_state_next = ST_WAIT_DONE;
                end else if (w_timeout) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_state_next = ST_WAIT_BUSY;
                end
            end
            ST_WAIT_DONE: begin
                if (!bus.uart_tx_busy) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_state_next = ST_WAIT_DONE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // TX sequencer state register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Byte storage; contents need no reset because the count gates every read.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus.uart_rx_data;
        end
    end

    // FIFO pointers and occupancy; break flushes everything.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (bus.uart_rx_break) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    // Start pulse, TX byte latch, busy-wait timer, receiver enable and sticky overflow.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_tx_en    <= 1'b0;
            r_tx_data  <= 8'h00;
            r_timer    <= '0;
            r_rx_en    <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_tx_en <= w_pop;
            r_rx_en <= bus.enable;
            if (w_pop) begin
                r_tx_data <= tx_map(r_mem[r_rd_ptr]);
            end
            if (r_state == ST_WAIT_BUSY) begin
                r_timer <= r_timer + TW'(1);
            end else begin
                r_timer <= '0;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (bus.clear_ovf) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign bus.uart_rx_en   = r_rx_en;
    assign bus.uart_tx_en   = r_tx_en;
    assign bus.uart_tx_data = r_tx_data;
    assign bus.fifo_count   = r_count;
    assign bus.overflow     = r_overflow;
endmodule

// File: tb/tb_uart_echo_responder.sv
// Bench for uart_echo_responder: directed scenarios plus random traffic against a queue-based reference model.
module tb_uart_echo_responder;
    localparam int DEPTH        = 16;
    localparam int BUSY_TIMEOUT = 8;

    logic clock;
    logic reset;

    uart_echo_responder_if #(.DEPTH(DEPTH)) bus ();

    uart_echo_responder #(
        .DEPTH        (DEPTH),
        .BUSY_TIMEOUT (BUSY_TIMEOUT)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    // Reference model: byte queue, sticky flag, and the cycle bookkeeping of the echo engine.
    logic [7:0] m_q[$];
    logic       m_ovf;
    logic       m_free;
    logic       m_rise;
    logic       m_txen;
    logic [7:0] m_txdata;
    int         m_start;
    int         m_rise_cyc;
    int         cyc = 0;

    // Uart core stand-in: busy for core_len cycles starting one cycle after each start pulse.
    logic hold_busy;
    int   next_len;
    int   core_start;
    int   core_len;

    logic [7:0] obs_bytes[$];
    int         obs_cycles[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] echo_of(input logic [7:0] b);
`ifdef UART_ECHO_UPCASE_EN
        if (b >= 8'h61 && b <= 8'h7A) return b - 8'h20;
`endif
        return b;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_ovf      = 1'b0;
        m_free     = 1'b1;
        m_rise     = 1'b0;
        m_txen     = 1'b0;
        m_txdata   = 8'h00;
        m_start    = 0;
        m_rise_cyc = 0;
        hold_busy  = 1'b0;
        core_start = -1;
        core_len   = 0;
    endtask

    // Asserts reset between clock edges and checks the outputs clear without waiting for a clock.
    task automatic do_reset();
        bus.enable        = 1'b0;
        bus.uart_rx_valid = 1'b0;
        bus.uart_rx_break = 1'b0;
        bus.clear_ovf     = 1'b0;
        bus.uart_tx_busy  = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check("rst_tx_en",   bus.uart_tx_en,   32'd0);
        check("rst_tx_data", bus.uart_tx_data, 32'd0);
        check("rst_count",   bus.fifo_count,   32'd0);
        check("rst_ovf",     bus.overflow,     32'd0);
        check("rst_rx_en",   bus.uart_rx_en,   32'd0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
    endtask

    // One clock of stimulus, model update and output comparison; entered and left at a falling edge.
    task automatic step(input logic en, input logic vld, input logic [7:0] dat,
                        input logic brk, input logic clr);
        logic busy;
        logic pop;
        logic ovf_set;
        busy = hold_busy || (core_start >= 0 && cyc >= core_start + 1 && cyc <= core_start + core_len);
        bus.enable        = en;
        bus.uart_rx_valid = vld;
        bus.uart_rx_data  = dat;
        bus.uart_rx_break = brk;
        bus.clear_ovf     = clr;
        bus.uart_tx_busy  = busy;

        pop     = m_free && (m_q.size() > 0) && !busy && !brk;
        ovf_set = 1'b0;
        m_txen  = pop;
        if (pop) m_txdata = echo_of(m_q.pop_front());
        if (brk) m_q.delete();
        else if (vld && en) begin
            if (m_q.size() < DEPTH) m_q.push_back(dat);
            else ovf_set = 1'b1;
        end
        if (ovf_set) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;

        if (pop) begin
            m_free     = 1'b0;
            m_start    = cyc + 1;
            m_rise     = 1'b0;
            core_start = cyc + 1;
            core_len   = next_len;
        end else if (!m_free && cyc >= m_start + 1) begin
            if (!m_rise) begin
                if (busy) begin
                    m_rise     = 1'b1;
                    m_rise_cyc = cyc;
                end else if (cyc == m_start + BUSY_TIMEOUT) begin
                    m_free = 1'b1;
                end
            end else if (cyc > m_rise_cyc && !busy) begin
                m_free = 1'b1;
            end
        end

        @(posedge clock);
        @(negedge clock);
        check("fifo_count", bus.fifo_count,   m_q.size());
        check("overflow",   bus.overflow,     m_ovf);
        check("tx_en",      bus.uart_tx_en,   m_txen);
        check("tx_data",    bus.uart_tx_data, m_txdata);
        check("rx_en",      bus.uart_rx_en,   en);
        if (bus.uart_tx_en === 1'b1) begin
            obs_bytes.push_back(bus.uart_tx_data);
            obs_cycles.push_back(cyc);
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic clear_obs();
        obs_bytes.delete();
        obs_cycles.delete();
    endtask

    initial begin
        int t0;
        logic [7:0] up_in  [3];
        logic [7:0] up_exp [3];
        reset     = 1'b1;
        next_len  = 0;
        model_reset();
        bus.uart_rx_data = 8'h00;
        do_reset();
        idle(3);

        // Single byte latency.
        next_len = 10;
        clear_obs();
        t0 = cyc;
        step(1'b1, 1'b1, 8'hA5, 1'b0, 1'b0);
        check("t1_count_n1", bus.fifo_count, 32'd1);
        idle(14);
        check("t1_n_tx", obs_bytes.size(), 32'd1);
        if (obs_bytes.size() >= 1) begin
            check("t1_byte",    obs_bytes[0],  32'hA5);
            check("t1_latency", obs_cycles[0], t0 + 1);
        end

        // Burst into a stalled transmitter, then drain.
        hold_busy = 1'b1;
        clear_obs();
        for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 8'(i), 1'b0, 1'b0);
        check("t2_count_sat", bus.fifo_count, 32'd16);
        check("t2_ovf",       bus.overflow,   32'd1);
        hold_busy = 1'b0;
        next_len  = 2;
        idle(100);
        check("t2_n_tx", obs_bytes.size(), 32'd16);
        for (int i = 0; i < 16 && i < obs_bytes.size(); i++) check("t2_order", obs_bytes[i], i);
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        check("t2_ovf_clr", bus.overflow, 32'd0);

        // Break during the first byte of six.
        next_len = 10;
        clear_obs();
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 8'h30 + 8'(i), 1'b0, 1'b0);
        idle(2);
        step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        check("t3_flush", bus.fifo_count, 32'd0);
        idle(30);
        check("t3_n_tx", obs_bytes.size(), 32'd1);
        if (obs_bytes.size() >= 1) check("t3_byte", obs_bytes[0], 32'h30);

        // Busy never rises: timeout spacing between starts.
        next_len = 0;
        clear_obs();
        step(1'b1, 1'b1, 8'h40, 1'b0, 1'b0);
        step(1'b1, 1'b1, 8'h41, 1'b0, 1'b0);
        idle(30);
        check("t4_n_tx", obs_bytes.size(), 32'd2);
        if (obs_bytes.size() >= 2) begin
            check("t4_gap",   obs_cycles[1] - obs_cycles[0], BUSY_TIMEOUT + 2);
            check("t4_byte1", obs_bytes[1], 32'h41);
        end

        // Reset while waiting for the core to finish, with three bytes queued.
        next_len = 10;
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 8'h50 + 8'(i), 1'b0, 1'b0);
        idle(5);
        check("t5_count_pre", bus.fifo_count, 32'd3);
        do_reset();
        clear_obs();
        idle(20);
        check("t5_no_tx", obs_bytes.size(), 32'd0);

        // Case folding.
        up_in[0] = 8'h61; up_in[1] = 8'h7B; up_in[2] = 8'h5A;
`ifdef UART_ECHO_UPCASE_EN
        up_exp[0] = 8'h41;
`else
        up_exp[0] = 8'h61;
`endif
        up_exp[1] = 8'h7B; up_exp[2] = 8'h5A;
        next_len = 1;
        clear_obs();
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, up_in[i], 1'b0, 1'b0);
            idle(6);
        end
        check("t6_n_tx", obs_bytes.size(), 32'd3);
        for (int i = 0; i < 3 && i < obs_bytes.size(); i++) check("t6_echo", obs_bytes[i], up_exp[i]);

        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            next_len = $urandom_range(0, 6);
            step(($urandom % 8) != 0, ($urandom % 3) == 0, 8'($urandom),
                 ($urandom % 60) == 0, ($urandom % 20) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
